// File: rtl/control_unit.sv
// control_unit: registered RV32I instruction decoder.
// Decodes instr_word into ALU/branch/jump/writeback controls; every output
// is a flop updated on the rising edge of clk (latency one cycle).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (forces the "invalid" decode)
//   instr_word   [31:0] instruction to decode
//   alu_ctrl     [3:0]  ALU operation code
//   shamt_en     ALU operand B taken from instr_word[24:20]
//   branch_ctrl  [2:0]  conditional-branch condition code (0 = none)
//   jump_ctrl    JAL/JALR
//   reg_write    write rd in the register file
//   inst_type    [2:0]  instruction format class (7 = invalid)
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_word,
    output logic [3:0]  alu_ctrl,
    output logic        shamt_en,
    output logic [2:0]  branch_ctrl,
    output logic        jump_ctrl,
    output logic        reg_write,
    output logic [2:0]  inst_type
);

    typedef enum logic [2:0] {
        TYPE_R       = 3'b000,
        TYPE_I       = 3'b001,
        TYPE_LOAD    = 3'b010,
        TYPE_S       = 3'b011,
        TYPE_B       = 3'b100,
        TYPE_U       = 3'b101,
        TYPE_J       = 3'b110,
        TYPE_INVALID = 3'b111
    } inst_type_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;

    inst_type_e inst_type_d, inst_type_q;
    alu_op_e    alu_ctrl_d, alu_ctrl_q;
    logic       shamt_en_d, shamt_en_q;
    logic [2:0] branch_ctrl_d, branch_ctrl_q;
    logic       jump_ctrl_d, jump_ctrl_q;
    logic       reg_write_d, reg_write_q;

    assign opcode = instr_word[6:0];
    assign funct3 = instr_word[14:12];
    assign alt    = instr_word[30];

    // Shared R/I funct3 mapping; alt selects SUB/SRA where it applies.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic sel_alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = sel_alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sel_alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        inst_type_d   = TYPE_INVALID;
        alu_ctrl_d    = ALU_ADD;
        shamt_en_d    = 1'b0;
        branch_ctrl_d = '0;
        jump_ctrl_d   = 1'b0;
        reg_write_d   = 1'b0;

        case (opcode)
            OP_R: begin
                inst_type_d = TYPE_R;
                alu_ctrl_d  = arith_op(funct3, alt);
                reg_write_d = 1'b1;
            end
            OP_I: begin
                inst_type_d = TYPE_I;
                // ADDI has no SUBI form, so bit30 is immediate data there.
                alu_ctrl_d  = arith_op(funct3, alt && (funct3 == 3'b101));
                shamt_en_d  = (funct3 == 3'b001) || (funct3 == 3'b101);
                reg_write_d = 1'b1;
            end
            OP_LOAD: begin
                inst_type_d = TYPE_LOAD;
                reg_write_d = 1'b1;
            end
            OP_STORE: begin
                inst_type_d = TYPE_S;
            end
            OP_BRANCH: begin
                // funct3 01x is not a defined branch; leave the invalid defaults.
                if (funct3[2:1] != 2'b01) begin
                    inst_type_d   = TYPE_B;
                    alu_ctrl_d    = ALU_SUB;
                    // 000/001 -> 1/2, 100..111 -> 3..6
                    branch_ctrl_d = funct3[2] ? (3'({1'b0, funct3[1:0]}) + 3'd3)
                                              : (3'({2'b00, funct3[0]}) + 3'd1);
                end
            end
            OP_LUI: begin
                inst_type_d = TYPE_U;
                alu_ctrl_d  = ALU_PASSB;
                reg_write_d = 1'b1;
            end
            OP_AUIPC: begin
                inst_type_d = TYPE_U;
                reg_write_d = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                inst_type_d = TYPE_J;
                jump_ctrl_d = 1'b1;
                reg_write_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_type_q   <= TYPE_INVALID;
            alu_ctrl_q    <= ALU_ADD;
            shamt_en_q    <= 1'b0;
            branch_ctrl_q <= '0;
            jump_ctrl_q   <= 1'b0;
            reg_write_q   <= 1'b0;
        end else begin
            inst_type_q   <= inst_type_d;
            alu_ctrl_q    <= alu_ctrl_d;
            shamt_en_q    <= shamt_en_d;
            branch_ctrl_q <= branch_ctrl_d;
            jump_ctrl_q   <= jump_ctrl_d;
            reg_write_q   <= reg_write_d;
        end
    end

    assign inst_type   = inst_type_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign shamt_en    = shamt_en_q;
    assign branch_ctrl = branch_ctrl_q;
    assign jump_ctrl   = jump_ctrl_q;
    assign reg_write   = reg_write_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against a
// table-driven decode model. Outputs are compared as one packed word
// {inst_type, alu_ctrl, shamt_en, branch_ctrl, jump_ctrl, reg_write}.
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr_word;
    logic [3:0]  alu_ctrl;
    logic        shamt_en;
    logic [2:0]  branch_ctrl;
    logic        jump_ctrl;
    logic        reg_write;
    logic [2:0]  inst_type;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [12:0] prev_exp;
    logic        have_prev;

    // funct3 -> ALU code for R/I arithmetic (alt adds one for SUB/SRA).
    int unsigned arith_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    // funct3 -> branch code; 0 marks an undefined branch.
    int unsigned branch_tab [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
    logic [6:0]  valid_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                   7'h37, 7'h17, 7'h6F, 7'h67};

    control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_word  (instr_word),
        .alu_ctrl    (alu_ctrl),
        .shamt_en    (shamt_en),
        .branch_ctrl (branch_ctrl),
        .jump_ctrl   (jump_ctrl),
        .reg_write   (reg_write),
        .inst_type   (inst_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] pack(input int unsigned ty, input int unsigned alu,
                                         input int unsigned sh, input int unsigned br,
                                         input int unsigned jp, input int unsigned rw);
        logic [2:0] t3;
        logic [3:0] a4;
        logic [2:0] b3;
        t3 = ty[2:0];
        a4 = alu[3:0];
        b3 = br[2:0];
        return {t3, a4, sh[0], b3, jp[0], rw[0]};
    endfunction

    function automatic logic [12:0] model(input logic [31:0] w, input logic r);
        int unsigned op, f3, alt;
        op  = int'(w[6:0]);
        f3  = int'(w[14:12]);
        alt = int'(w[30]);
        if (r) return pack(7, 0, 0, 0, 0, 0);
        case (op)
            'h33: return pack(0, arith_tab[f3] + ((f3 == 0 || f3 == 5) ? alt : 0), 0, 0, 0, 1);
            'h13: return pack(1, arith_tab[f3] + ((f3 == 5) ? alt : 0),
                              (f3 == 1 || f3 == 5) ? 1 : 0, 0, 0, 1);
            'h03: return pack(2, 0, 0, 0, 0, 1);
            'h23: return pack(3, 0, 0, 0, 0, 0);
            'h63: return (branch_tab[f3] == 0) ? pack(7, 0, 0, 0, 0, 0)
                                               : pack(4, 1, 0, branch_tab[f3], 0, 0);
            'h37: return pack(5, 10, 0, 0, 0, 1);
            'h17: return pack(5, 0, 0, 0, 0, 1);
            'h6F, 'h67: return pack(6, 0, 0, 0, 1, 1);
            default: return pack(7, 0, 0, 0, 0, 0);
        endcase
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (type,alu,sh,br,jmp,rw)", tag, obs, exp);
    endtask

    function automatic logic [12:0] outs();
        return {inst_type, alu_ctrl, shamt_en, branch_ctrl, jump_ctrl, reg_write};
    endfunction

    // Drive one cycle of inputs: outputs must hold until the next edge,
    // then show the decode (or reset values) of what was driven.
    task automatic step(input logic r, input logic [31:0] w, input string tag);
        logic [12:0] exp;
        rst = r;
        instr_word = w;
        #1;
        if (have_prev) check({tag, "_hold"}, outs(), prev_exp);
        @(posedge clk);
        #1;
        exp = model(w, r);
        check(tag, outs(), exp);
        prev_exp = exp;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        n_checks   = 0;
        n_pass     = 0;
        have_prev  = 1'b0;
        prev_exp   = '0;
        rst        = 1'b1;
        instr_word = 32'h015A82B3;

        step(1'b1, 32'h015A82B3, "reset");
        check("reset_const", outs(), 13'b111_0000_0_000_0_0);
        step(1'b1, 32'h6F, "reset_hold2");

        step(1'b0, 32'h015A82B3, "add");
        check("add_const", outs(), 13'b000_0000_0_000_0_1);
        step(1'b0, 32'h405A8333, "sub");
        step(1'b0, 32'h004A92B3, "sll");
        step(1'b0, 32'h20998393, "addi");
        step(1'b0, 32'h6099_8393, "addi_alt");
        step(1'b0, 32'h0F56D693, "srli");
        check("srli_const", outs(), 13'b001_0110_1_000_0_1);
        step(1'b0, 32'h4F56D693, "srai");
        step(1'b0, 32'h0F56B683, "load");
        step(1'b0, 32'h0F56A6A3, "store");
        step(1'b0, 32'h0F56B6B7, "lui");
        step(1'b0, 32'h0F56B697, "auipc");
        step(1'b0, 32'h0F56F6E3, "bgeu");
        check("bgeu_const", outs(), 13'b100_0001_0_110_0_0);
        step(1'b0, 32'h0F56C6E3, "blt");
        step(1'b0, 32'h0F56A6E3, "branch_f3_010");
        step(1'b0, 32'h0F56B6E3, "branch_f3_011");
        step(1'b0, 32'h0F56F6EF, "jal");
        check("jal_const", outs(), 13'b110_0000_0_000_1_1);
        step(1'b0, 32'h0F5686E7, "jalr");
        step(1'b0, 32'h0000007F, "invalid_7f");
        step(1'b0, 32'h015A82B3, "add_again");
        step(1'b1, 32'h015A82B3, "rst_mid");
        step(1'b1, 32'h0F56F6EF, "rst_mid_hold");
        step(1'b0, 32'h0F56F6EF, "rst_release");

        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            if ($urandom_range(0, 4) != 0) w[6:0] = valid_ops[$urandom_range(0, 8)];
            step(($urandom_range(0, 19) == 0), w, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
